// File: rtl/led_pulse_pkg.sv
// Shared types and elaboration helpers for the multi-channel LED pulse generator.
package led_pulse_pkg;

    // Widest supported period/duty field; narrower configs are zero-extended into it.
    localparam int CFG_W_MAX = 16;

    typedef struct packed {
        logic [CFG_W_MAX-1:0] period;
        logic [CFG_W_MAX-1:0] duty;
    } chan_cfg_t;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int presc_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

    function automatic int chan_idx_width(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/led_pulse_chan.sv
// One LED channel: tick-driven period/duty counter with a shadow config
// that is swapped in at the period wrap so the output never glitches.
module led_pulse_chan
    import led_pulse_pkg::*;
#(
    parameter int PERIOD_W = 12
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      tick,
    input  logic      run,
    input  logic      wr,
    input  chan_cfg_t cfg,
    output logic      pending,
    output logic      led
);

    chan_cfg_t            act_q, act_d;
    chan_cfg_t            sh_q, sh_d;
    logic [PERIOD_W-1:0]  cnt_q, cnt_d;
    logic                 pending_q, pending_d;
    logic                 led_q, led_d;
    logic [CFG_W_MAX-1:0] cnt_ext;
    logic                 period_zero;
    logic                 wrap;

    assign cnt_ext     = CFG_W_MAX'(cnt_q);
    assign period_zero = (act_q.period == '0);
    assign wrap        = (cnt_ext == act_q.period - 1'b1);

    always_comb begin
        act_d     = act_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;

        if (!run) begin
            cnt_d = '0;
        end else if (tick) begin
            if (period_zero) begin
                cnt_d = '0;
            end else if (wrap) begin
                cnt_d = '0;
                if (pending_q) begin
                    act_d     = sh_q;
                    pending_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // An idle or stopped channel has no period boundary to wait for.
        if (wr) begin
            sh_d = cfg;
            if (period_zero || !run) begin
                act_d     = cfg;
                cnt_d     = '0;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    assign led_d = run && !period_zero && (cnt_ext < act_q.duty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q     <= '0;
            sh_q      <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            act_q     <= act_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            led_q     <= led_d;
        end
    end

    assign pending = pending_q;
    assign led     = led_q;

endmodule

// File: rtl/led_pulse_gen.sv
// Multi-channel LED pulse generator: shared prescaler, per-channel counters, cfg handshake.
// Define LED_PULSE_SYNC_EN to pass `locked` through a 2-flop synchroniser.
module led_pulse_gen
    import led_pulse_pkg::*;
#(
    parameter int  CLK_HZ   = 48_000_000,
    parameter int  TICK_HZ  = 1000,
    parameter int  CHANNELS = 4,
    parameter int  PERIOD_W = 12,
    localparam int CH_W     = chan_idx_width(CHANNELS)
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                locked,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [PERIOD_W-1:0] cfg_duty,
    output logic                tick,
    output logic [CHANNELS-1:0] led
);

    localparam int            DIV        = calc_div(CLK_HZ, TICK_HZ);
    localparam int            PW         = presc_width(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic                run;
    logic [PW-1:0]       presc_q, presc_d;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] wr;
    chan_cfg_t           cfg_in;

`ifdef LED_PULSE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], locked};
        end
    end

    assign run = sync_q[1];
`else
    assign run = locked;
`endif

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (!run || presc_q == PRESC_LAST) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick = run && (presc_q == PRESC_LAST);

    assign cfg_in.period = CFG_W_MAX'(cfg_period);
    assign cfg_in.duty   = CFG_W_MAX'(cfg_duty);

    // Out-of-range channel indices fall through with ready high and no write strobe.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(cfg_ch) == i) begin
                cfg_ready = !pending[i];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign wr[g] = cfg_valid && !pending[g] && (int'(cfg_ch) == g);

        led_pulse_chan #(
            .PERIOD_W(PERIOD_W)
        ) u_chan (
            .clk    (sys_clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .run    (run),
            .wr     (wr[g]),
            .cfg    (cfg_in),
            .pending(pending[g]),
            .led    (led[g])
        );
    end

endmodule
